// File: rtl/inta_sequence_controller_if.sv
// rtl/inta_sequence_controller_if.sv - INTA# sequencing signal bundle between control logic and the sequence controller
interface inta_sequence_controller_if;
    logic       interrupt_acknowledge_n;
    logic       u8086_or_mcs80_config;
    logic       cascade_slave;
    logic       cascade_slave_match;
    logic [7:0] interrupt;
    logic [1:0] control_state;
    logic [7:0] interrupt_when_ack1;
    logic       cascade_output_ack_2_3;
    logic       isr_set;
    logic       spurious_interrupt;
    logic       end_of_acknowledge_sequence;
    logic       sequence_abort;

    modport master (
        output interrupt_acknowledge_n, u8086_or_mcs80_config, cascade_slave,
               cascade_slave_match, interrupt,
        input  control_state, interrupt_when_ack1, cascade_output_ack_2_3, isr_set,
               spurious_interrupt, end_of_acknowledge_sequence, sequence_abort
    );

    modport slave (
        input  interrupt_acknowledge_n, u8086_or_mcs80_config, cascade_slave,
               cascade_slave_match, interrupt,
        output control_state, interrupt_when_ack1, cascade_output_ack_2_3, isr_set,
               spurious_interrupt, end_of_acknowledge_sequence, sequence_abort
    );
endinterface

// File: rtl/inta_sequence_controller.sv
// rtl/inta_sequence_controller.sv - 8259A INTA# acknowledge sequencer (optional inter-pulse timeout via INTA_TIMEOUT_EN)
module inta_sequence_controller #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    inta_sequence_controller_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACK1 = 2'b01,
        ST_ACK2 = 2'b10,
        ST_ACK3 = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic       inta_meta_q, inta_sync_q, inta_prev_q;
    logic       inta_fall, inta_rise;
    logic       mode_8086_q, mode_8086_d;
    logic [7:0] irq_ack1_q, irq_ack1_d;
    logic       spurious_q, spurious_d;
    logic       isr_set_q, isr_set_d;
    logic       eoa_q, eoa_d;
    logic       cas_out_q, cas_out_d;
    logic       abort_q, abort_d;
    logic       timeout_hit;

    if (TIMEOUT_CYCLES >= (1 << TIMEOUT_WIDTH)) begin : g_cfg_bad
        $error("TIMEOUT_WIDTH too narrow for TIMEOUT_CYCLES");
    end

    assign inta_fall = inta_prev_q & ~inta_sync_q;
    assign inta_rise = ~inta_prev_q & inta_sync_q;

`ifdef INTA_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts only idle-high time inside a sequence; a fall always restarts it.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        timeout_hit = 1'b0;
        if (state_q == ST_IDLE || inta_fall || !inta_sync_q) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt_d   = '0;
            timeout_hit = 1'b1;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inta_meta_q <= 1'b1;
            inta_sync_q <= 1'b1;
            inta_prev_q <= 1'b1;
            state_q     <= ST_IDLE;
            mode_8086_q <= 1'b0;
            irq_ack1_q  <= 8'h00;
            spurious_q  <= 1'b0;
            isr_set_q   <= 1'b0;
            eoa_q       <= 1'b0;
            cas_out_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            inta_meta_q <= bus.interrupt_acknowledge_n;
            inta_sync_q <= inta_meta_q;
            inta_prev_q <= inta_sync_q;
            state_q     <= state_d;
            mode_8086_q <= mode_8086_d;
            irq_ack1_q  <= irq_ack1_d;
            spurious_q  <= spurious_d;
            isr_set_q   <= isr_set_d;
            eoa_q       <= eoa_d;
            cas_out_q   <= cas_out_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (inta_fall) state_d = ST_ACK1;
            ST_ACK1: if (inta_fall) state_d = ST_ACK2;
            ST_ACK2: begin
                if (mode_8086_q && inta_rise)       state_d = ST_IDLE;
                else if (!mode_8086_q && inta_fall) state_d = ST_ACK3;
            end
            ST_ACK3: if (inta_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) state_d = ST_IDLE;
    end

    // Strobes are registered so they line up with the cycle the new state becomes visible.
    always_comb begin
        mode_8086_d = mode_8086_q;
        irq_ack1_d  = irq_ack1_q;
        spurious_d  = spurious_q;
        isr_set_d   = 1'b0;
        eoa_d       = 1'b0;
        abort_d     = timeout_hit;
        if (state_q == ST_IDLE && state_d == ST_ACK1) begin
            mode_8086_d = bus.u8086_or_mcs80_config;
            if (bus.interrupt == 8'h00) begin
                irq_ack1_d = 8'h80;
                spurious_d = 1'b1;
            end else begin
                irq_ack1_d = bus.interrupt;
                spurious_d = 1'b0;
                isr_set_d  = 1'b1;
            end
        end else if (state_q != ST_IDLE && state_d == ST_IDLE) begin
            irq_ack1_d = 8'h00;
            spurious_d = 1'b0;
            eoa_d      = ~timeout_hit;
        end
        cas_out_d = (state_d == ST_ACK2 || state_d == ST_ACK3)
                  & (~bus.cascade_slave | bus.cascade_slave_match);
    end

    assign bus.control_state               = state_q;
    assign bus.interrupt_when_ack1         = irq_ack1_q;
    assign bus.cascade_output_ack_2_3      = cas_out_q;
    assign bus.isr_set                     = isr_set_q;
    assign bus.spurious_interrupt          = spurious_q;
    assign bus.end_of_acknowledge_sequence = eoa_q;
    assign bus.sequence_abort              = abort_q;
endmodule

// File: tb/tb_inta_sequence_controller.sv
// tb/tb_inta_sequence_controller.sv - directed table-driven bench for inta_sequence_controller
module tb_inta_sequence_controller;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    inta_sequence_controller_if bus ();

    inta_sequence_controller #(
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    int          isr_cnt = 0, eoa_cnt = 0, abort_cnt = 0, nchg = 0;
    logic [31:0] trace = '0;
    logic [1:0]  last_state = 2'b00;
    logic [7:0]  cap_irq1 = '0, cap_irq2 = '0;
    logic        cap_spur1 = 1'b0, cap_cas2 = 1'b0;

    always @(negedge clock) begin
        if (bus.isr_set) isr_cnt <= isr_cnt + 1;
        if (bus.end_of_acknowledge_sequence) eoa_cnt <= eoa_cnt + 1;
        if (bus.sequence_abort) abort_cnt <= abort_cnt + 1;
        if (bus.control_state != last_state) begin
            trace      <= {trace[29:0], bus.control_state};
            nchg       <= nchg + 1;
            last_state <= bus.control_state;
        end
        if (bus.control_state == 2'b01) begin
            cap_irq1  <= bus.interrupt_when_ack1;
            cap_spur1 <= bus.spurious_interrupt;
        end
        if (bus.control_state == 2'b10) begin
            cap_irq2 <= bus.interrupt_when_ack1;
            cap_cas2 <= bus.cascade_output_ack_2_3;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse();
        @(posedge clock); #2;
        bus.interrupt_acknowledge_n = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        bus.interrupt_acknowledge_n = 1'b1;
        repeat (4) @(posedge clock);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_state"}, 32'(bus.control_state), 32'h0);
        check({tag, "_irq"},   32'(bus.interrupt_when_ack1), 32'h0);
        check({tag, "_strobes"}, 32'({bus.cascade_output_ack_2_3, bus.isr_set, bus.spurious_interrupt,
                                      bus.end_of_acknowledge_sequence, bus.sequence_abort}), 32'h0);
    endtask

    typedef struct {
        logic       mode;
        logic       slave;
        logic       match;
        logic [7:0] irq;
        logic [7:0] exp_irq;
        logic       exp_spur;
        int         exp_isr;
        logic       exp_cas;
        logic [7:0] exp_trace;
        int         exp_chg;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int i0, e0, c0;
        logic [31:0] mask;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h04, 8'h04, 1'b0, 1, 1'b1, 8'b00_01_10_00, 3};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h20, 8'h20, 1'b0, 1, 1'b1, 8'b01_10_11_00, 4};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 0, 1'b1, 8'b00_01_10_00, 3};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1, 1'b0, 8'b00_01_10_00, 3};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h10, 8'h10, 1'b0, 1, 1'b1, 8'b00_01_10_00, 3};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h40, 8'h40, 1'b0, 1, 1'b1, 8'b00_01_10_00, 3};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h80, 1'b1, 0, 1'b1, 8'b01_10_11_00, 4};

        bus.interrupt_acknowledge_n = 1'b1;
        bus.u8086_or_mcs80_config   = 1'b1;
        bus.cascade_slave           = 1'b0;
        bus.cascade_slave_match     = 1'b0;
        bus.interrupt               = 8'h00;

        repeat (3) @(posedge clock);
        #3;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clock);

        // Latency: ACK1 is visible after the 3rd rising edge following the INTA# fall.
        bus.interrupt = 8'h04;
        @(posedge clock); #2;
        bus.interrupt_acknowledge_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check("lat_edge2_state", 32'(bus.control_state), 32'h0);
        @(negedge clock);
        check("lat_edge3_state", 32'(bus.control_state), 32'h1);
        check("lat_edge3_isr", 32'(bus.isr_set), 32'h1);
        @(negedge clock);
        check("lat_isr_one_cycle", 32'(bus.isr_set), 32'h0);
        #2;
        bus.interrupt_acknowledge_n = 1'b1;
        repeat (4) @(posedge clock);
        pulse();
        repeat (4) @(posedge clock);
        check("lat_back_idle", 32'(bus.control_state), 32'h0);

        for (int v = 0; v < 7; v++) begin
            bus.u8086_or_mcs80_config = vecs[v].mode;
            bus.cascade_slave         = vecs[v].slave;
            bus.cascade_slave_match   = vecs[v].match;
            bus.interrupt             = vecs[v].irq;
            @(negedge clock);
            i0 = isr_cnt; e0 = eoa_cnt; c0 = nchg;
            pulse();
            // Mid-sequence changes on interrupt and config must be ignored.
            bus.interrupt             = ~vecs[v].irq;
            bus.u8086_or_mcs80_config = ~vecs[v].mode;
            pulse();
            if (!vecs[v].mode) pulse();
            repeat (4) @(posedge clock);
            @(negedge clock);
            mask = (32'h1 << (2 * vecs[v].exp_chg)) - 32'h1;
            check($sformatf("v%0d_trace", v), trace & mask, 32'(vecs[v].exp_trace));
            check($sformatf("v%0d_nchg", v), 32'(nchg - c0), 32'(vecs[v].exp_chg));
            check($sformatf("v%0d_irq_ack1", v), 32'(cap_irq1), 32'(vecs[v].exp_irq));
            check($sformatf("v%0d_irq_ack2", v), 32'(cap_irq2), 32'(vecs[v].exp_irq));
            check($sformatf("v%0d_spur", v), 32'(cap_spur1), 32'(vecs[v].exp_spur));
            check($sformatf("v%0d_isr_cnt", v), 32'(isr_cnt - i0), 32'(vecs[v].exp_isr));
            check($sformatf("v%0d_cas", v), 32'(cap_cas2), 32'(vecs[v].exp_cas));
            check($sformatf("v%0d_eoa_cnt", v), 32'(eoa_cnt - e0), 32'h1);
            check($sformatf("v%0d_idle_irq", v), 32'(bus.interrupt_when_ack1), 32'h0);
            check($sformatf("v%0d_idle_spur", v), 32'(bus.spurious_interrupt), 32'h0);
        end

        // MCS-80: no end strobe after the 2nd rise; then async reset mid-ACK2.
        bus.u8086_or_mcs80_config = 1'b0;
        bus.cascade_slave         = 1'b0;
        bus.interrupt             = 8'h08;
        @(negedge clock);
        e0 = eoa_cnt;
        pulse();
        pulse();
        @(negedge clock);
        check("mcs_ack2_hold", 32'(bus.control_state), 32'h2);
        check("mcs_no_eoa_2nd", 32'(eoa_cnt - e0), 32'h0);
        check("mcs_cas_before_rst", 32'(bus.cascade_output_ack_2_3), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("post_rst_idle", 32'(bus.control_state), 32'h0);
        bus.u8086_or_mcs80_config = 1'b1;
        bus.interrupt             = 8'h02;
        i0 = isr_cnt; e0 = eoa_cnt;
        pulse();
        @(negedge clock);
        check("post_rst_ack1", 32'(bus.control_state), 32'h1);
        check("post_rst_irq", 32'(bus.interrupt_when_ack1), 32'h02);
        check("post_rst_isr", 32'(isr_cnt - i0), 32'h1);
        pulse();
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("post_rst_done", 32'(bus.control_state), 32'h0);
        check("post_rst_eoa", 32'(eoa_cnt - e0), 32'h1);

        // One pulse then INTA# held high well past the timeout.
        bus.interrupt = 8'h08;
        @(negedge clock);
        e0 = eoa_cnt; i0 = abort_cnt;
        pulse();
        repeat (40) @(posedge clock);
        @(negedge clock);
`ifdef INTA_TIMEOUT_EN
        check("tmo_state", 32'(bus.control_state), 32'h0);
        check("tmo_abort_cnt", 32'(abort_cnt - i0), 32'h1);
        check("tmo_no_eoa", 32'(eoa_cnt - e0), 32'h0);
        check("tmo_irq_clr", 32'(bus.interrupt_when_ack1), 32'h0);
`else
        check("notmo_state", 32'(bus.control_state), 32'h1);
        check("notmo_abort_cnt", 32'(abort_cnt - i0), 32'h0);
        check("notmo_no_eoa", 32'(eoa_cnt - e0), 32'h0);
        check("notmo_irq_held", 32'(bus.interrupt_when_ack1), 32'h08);
`endif
        #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
